// File: rtl/mul_seq_if.sv
// Request/response and multiplier-side signals of the multiply sequencer.
// master = execute stage plus multiplier datapath, slave = mul_seq_ctrl.
interface mul_seq_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             req_valid_i;
   logic             req_ready_o;
   logic [1:0]       req_op_i;
   logic [XLEN-1:0]  req_rs1_i;
   logic [XLEN-1:0]  req_rs2_i;
   logic [TAG_W-1:0] req_tag_i;
   logic             flush_i;
   logic             resp_valid_o;
   logic             resp_ready_i;
   logic [XLEN-1:0]  resp_data_o;
   logic [TAG_W-1:0] resp_tag_o;
   logic             mul_en_o;
   logic             mul_op_o;
   logic [XLEN:0]    mul_a_o;
   logic [XLEN:0]    mul_b_o;
   logic [XLEN-1:0]  mul_result_i;
   logic             mul_finish_i;
   logic             busy_o;

   modport master (
      output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_tag_i, flush_i,
             resp_ready_i, mul_result_i, mul_finish_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o,
             mul_en_o, mul_op_o, mul_a_o, mul_b_o, busy_o
   );

   modport slave (
      input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_tag_i, flush_i,
             resp_ready_i, mul_result_i, mul_finish_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o,
             mul_en_o, mul_op_o, mul_a_o, mul_b_o, busy_o
   );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the combinational Booth multiplier: registers operands, holds
// the multiplier enabled for MUL_LAT cycles, returns the result with its tag.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | multiplier enabled, waiting out the multicycle window
// RESP  | result held on the response channel until consumed
module mul_seq_ctrl #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 5,
   parameter int MUL_LAT  = 2,
   parameter int CACHE_EN = 1
) (
   input logic    clk,
   input logic    rst,
   mul_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic [2:0] LAT_M1   = 3'(MUL_LAT - 1);
   localparam bit         CACHE_ON = (CACHE_EN != 0);

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [1:0]       op_q;
   logic [XLEN-1:0]  rs1_q, rs2_q, result_q;
   logic [TAG_W-1:0] tag_q;

   logic             cache_vld_q;
   logic [1:0]       cache_op_q;
   logic [XLEN-1:0]  cache_rs1_q, cache_rs2_q, cache_data_q;

   logic accept, zero_op, cache_hit, capture;
   logic a_msb, b_msb;

   assign zero_op   = (bus.req_rs1_i == '0) || (bus.req_rs2_i == '0);
   assign cache_hit = CACHE_ON && cache_vld_q && (bus.req_op_i == cache_op_q)
                      && (bus.req_rs1_i == cache_rs1_q) && (bus.req_rs2_i == cache_rs2_q);

   // MULHU zero-extends rs1; both unsigned-rs2 ops (MULHSU, MULHU) have op[1] set
   assign a_msb = (op_q != 2'b11) ? rs1_q[XLEN-1] : 1'b0;
   assign b_msb = (!op_q[1])      ? rs2_q[XLEN-1] : 1'b0;

   always_comb begin
      state_d          = state_q;
      cnt_d            = '0;
      accept           = 1'b0;
      capture          = 1'b0;
      bus.req_ready_o  = 1'b0;
      bus.resp_valid_o = 1'b0;
      bus.mul_en_o     = 1'b0;
      bus.mul_op_o     = 1'b0;
      bus.mul_a_o      = '0;
      bus.mul_b_o      = '0;
      unique case (state_q)
         IDLE: begin
            bus.req_ready_o = 1'b1;
            if (bus.req_valid_i && !bus.flush_i) begin
               accept  = 1'b1;
               state_d = (zero_op || cache_hit) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            bus.mul_en_o = 1'b1;
            bus.mul_op_o = (op_q != 2'b00);
            bus.mul_a_o  = {a_msb, rs1_q};
            bus.mul_b_o  = {b_msb, rs2_q};
            cnt_d        = (cnt_q == LAT_M1) ? cnt_q : cnt_q + 3'd1;
            if (bus.flush_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAT_M1 && bus.mul_finish_i) begin
               capture = 1'b1;
               state_d = RESP;
               cnt_d   = '0;
            end
         end
         RESP: begin
            bus.resp_valid_o = 1'b1;
            if (bus.flush_i || bus.resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         tag_q        <= '0;
         result_q     <= '0;
         cache_vld_q  <= 1'b0;
         cache_op_q   <= '0;
         cache_rs1_q  <= '0;
         cache_rs2_q  <= '0;
         cache_data_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            op_q  <= bus.req_op_i;
            rs1_q <= bus.req_rs1_i;
            rs2_q <= bus.req_rs2_i;
            tag_q <= bus.req_tag_i;
         end
         if (accept && zero_op)        result_q <= '0;
         else if (accept && cache_hit) result_q <= cache_data_q;
         else if (capture)             result_q <= bus.mul_result_i;
         if (capture && CACHE_ON) begin
            cache_vld_q  <= 1'b1;
            cache_op_q   <= op_q;
            cache_rs1_q  <= rs1_q;
            cache_rs2_q  <= rs2_q;
            cache_data_q <= bus.mul_result_i;
         end
      end
   end

   assign bus.resp_data_o = result_q;
   assign bus.resp_tag_o  = tag_q;
   assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural multiplier stub.
module tb_mul_seq_ctrl;
   localparam int XLEN = 32, TAG_W = 5, MUL_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_seq_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
   mul_seq_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT), .CACHE_EN(1)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int vectors = 0, miscompares = 0;
   int hold_cnt = 0;
   logic [32:0] first_a, first_b;
   logic        first_op;
   logic        cm_vld = 1'b0;
   logic [1:0]  cm_op;
   logic [31:0] cm_a, cm_b;

   function automatic logic [31:0] mul_stub(input logic [32:0] a, input logic [32:0] b, input logic hi);
      logic signed [65:0] p;
      p = $signed({{33{a[32]}}, a}) * $signed({{33{b[32]}}, b});
      return hi ? p[63:32] : p[31:0];
   endfunction

   assign bus.mul_result_i = mul_stub(bus.mul_a_o, bus.mul_b_o, bus.mul_op_o);
   assign bus.mul_finish_i = bus.mul_en_o && (hold_cnt == 0);

   // ISA reference: MUL low half, MULH s*s, MULHSU s*u, MULHU u*u
   function automatic logic [31:0] isa_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] sa, sb2, p;
      sa  = (op == 2'b11) ? $signed({34'b0, a}) : $signed({{34{a[31]}}, a});
      sb2 = (op >= 2'b10) ? $signed({34'b0, b}) : $signed({{34{b[31]}}, b});
      p   = sa * sb2;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic int predict_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (a == 0 || b == 0) return 1;
      if (cm_vld && cm_op == op && cm_a == a && cm_b == b) return 1;
      return MUL_LAT + 1;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_data, input int exp_lat,
                        input int stall);
      exp_t e;
      int   n, en_cnt;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = op;
      bus.req_rs1_i   = a;
      bus.req_rs2_i   = b;
      bus.req_tag_i   = tag;
      @(posedge clk);
      sb.push_back('{exp_data, tag, exp_lat});
      n = 0;
      en_cnt = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         bus.req_valid_i = 1'b0;
         if (bus.resp_valid_o) begin
            n = i;
            break;
         end
         if (bus.mul_en_o) begin
            if (en_cnt == 0) begin
               first_a  = bus.mul_a_o;
               first_b  = bus.mul_b_o;
               first_op = bus.mul_op_o;
            end
            en_cnt++;
            if (hold_cnt > 0) hold_cnt--;
         end
      end
      e = sb.pop_front();
      if (n == 0) begin
         check("resp_timeout", 0, 1);
         return;
      end
      check("resp_data", bus.resp_data_o, e.data);
      check("resp_tag", bus.resp_tag_o, e.tag);
      check("latency", n, e.lat);
      check("mul_en_cycles", en_cnt, (e.lat == 1) ? 0 : e.lat - 1);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check("stall_valid", bus.resp_valid_o, 1);
         check("stall_data", bus.resp_data_o, e.data);
         check("stall_tag", bus.resp_tag_o, e.tag);
         check("stall_req_ready", bus.req_ready_o, 0);
      end
      bus.resp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready_i = 1'b0;
      check("post_resp_valid", bus.resp_valid_o, 0);
      check("post_resp_busy", bus.busy_o, 0);
      if (e.lat > 1) begin
         cm_vld = 1'b1;
         cm_op  = op;
         cm_a   = a;
         cm_b   = b;
      end
   endtask

   task automatic rand_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      do_op(op, a, b, 5'($urandom), isa_mul(op, a, b), predict_lat(op, a, b), $urandom_range(0, 2));
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      bus.req_valid_i  = 1'b1;
      bus.req_op_i     = 2'b11;
      bus.req_rs1_i    = 32'hFFFF_FFFF;
      bus.req_rs2_i    = 32'hFFFF_FFFF;
      bus.req_tag_i    = 5'd1;
      bus.flush_i      = 1'b0;
      bus.resp_ready_i = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_req_ready", bus.req_ready_o, 1);
      check("rst_resp_valid", bus.resp_valid_o, 0);
      check("rst_mul_en", bus.mul_en_o, 0);
      check("rst_busy", bus.busy_o, 0);
      bus.req_valid_i = 1'b0;
      rst = 1'b0;

      do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 3, 0);
      check("mulhu_a", first_a, 33'h0_FFFF_FFFF);
      check("mulhu_b", first_b, 33'h0_FFFF_FFFF);
      check("mulhu_op", first_op, 1);
      do_op(2'b00, 32'h0, 32'h1234_5678, 5'd2, 32'h0, 1, 0);
      do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1, 0);
      do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 3, 0);
      do_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5, 32'hFFFF_FFFF, 3, 0);
      check("mulhsu_a", first_a, 33'h1_FFFF_FFFF);
      check("mulhsu_b", first_b, 33'h0_0000_0002);
      do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 5'd6, 32'hFFFF_FFEB, 3, 0);
      check("mul_op_low", first_op, 0);
      do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 5'd7, 32'hFFFF_FFEB, 1, 5);

      // flush in the first ISSUE cycle
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = 2'b01;
      bus.req_rs1_i   = 32'h8000_0001;
      bus.req_rs2_i   = 32'h7FFF_FFFF;
      bus.req_tag_i   = 5'd8;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      check("flush_issue_en", bus.mul_en_o, 1);
      bus.flush_i = 1'b1;
      @(negedge clk);
      bus.flush_i = 1'b0;
      check("flush_busy", bus.busy_o, 0);
      check("flush_mul_en", bus.mul_en_o, 0);
      repeat (4) begin
         @(negedge clk);
         check("flush_no_resp", bus.resp_valid_o, 0);
      end
      do_op(2'b01, 32'h8000_0001, 32'h7FFF_FFFF, 5'd9, isa_mul(2'b01, 32'h8000_0001, 32'h7FFF_FFFF), 3, 0);

      // request together with flush in IDLE is dropped
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_rs1_i   = 32'h0;
      bus.flush_i     = 1'b1;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      check("flush_idle_busy", bus.busy_o, 0);
      check("flush_idle_resp", bus.resp_valid_o, 0);

      // finish arrives late: ISSUE stretches past the window
      hold_cnt = 4;
      do_op(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd10, 32'h0000_0001, 5, 0);

      for (int i = 0; i < 14; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 3))
            0: a = 32'h0;
            1: if (cm_vld) begin op = cm_op; a = cm_a; b = cm_b; end
            default: ;
         endcase
         rand_op(op, a, b);
      end

      // async reset mid-operation clears the cache
      do_op(2'b10, 32'h8765_4321, 32'h1357_9BDF, 5'd11, isa_mul(2'b10, 32'h8765_4321, 32'h1357_9BDF),
            predict_lat(2'b10, 32'h8765_4321, 32'h1357_9BDF), 0);
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_op_i    = 2'b00;
      bus.req_rs1_i   = 32'h5;
      bus.req_rs2_i   = 32'h6;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      check("pre_rst_en", bus.mul_en_o, 1);
      #1 rst = 1'b1;
      #1;
      check("arst_mul_en", bus.mul_en_o, 0);
      check("arst_busy", bus.busy_o, 0);
      check("arst_req_ready", bus.req_ready_o, 1);
      check("arst_resp_valid", bus.resp_valid_o, 0);
      @(negedge clk);
      rst = 1'b0;
      cm_vld = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("arst_no_resp", bus.resp_valid_o, 0);
      end
      do_op(2'b10, 32'h8765_4321, 32'h1357_9BDF, 5'd12, isa_mul(2'b10, 32'h8765_4321, 32'h1357_9BDF), 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
